// File: rtl/alu_res_if.sv
// Result handshake between the signed ALU (producer) and the result display
// (consumer): one 5-bit two's-complement result or a 1-bit compare flag per
// valid/ready transfer.
interface alu_res_if;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;
    logic       res_is_flag;

    modport master (
        output res_valid,
        output res_data,
        output res_is_flag,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_is_flag,
        output res_ready
    );
endinterface : alu_res_if

// File: rtl/alu_result_display.sv
// alu_result_display
// Accepts one ALU result per handshake, converts it to sign-magnitude
// decimal (or a compare flag) and drives a time-multiplexed 3-digit
// seven-segment display (sign, tens, ones) plus sign and flag LEDs.
// Optional build macro ALU_DISP_HEX_EN: numeric results are shown as raw hex
// (tens = bit 4, ones = bits 3:0, no leading-zero suppression, sign blank).
module alu_result_display #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_res_if.slave   res,
    output logic [7:0] seg_out,
    output logic [2:0] seg_an,
    output logic       sign_led,
    output logic       flag_led
);

    localparam logic [7:0]       SEG_BLANK = 8'hFF;
    localparam logic [7:0]       SEG_MINUS = 8'hBF;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Active-low segment pattern for one hex digit; dp always off.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Active-low one-hot digit enable for scan position 0=ones,1=tens,2=sign.
    function automatic logic [2:0] an_decode(input logic [1:0] idx);
        logic [2:0] an;
        case (idx)
            2'd0:    an = 3'b110;
            2'd1:    an = 3'b101;
            2'd2:    an = 3'b011;
            default: an = 3'b111;
        endcase
        return an;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [4:0]       cap_data_r;
    logic             cap_flag_r;
    logic [7:0]       dig_ones_r;
    logic [7:0]       dig_tens_r;
    logic [7:0]       dig_sign_r;
    logic             sign_led_r;
    logic             flag_led_r;
    logic [CNT_W-1:0] div_cnt_r;
    logic [1:0]       idx_r;
    logic [7:0]       seg_out_r;
    logic [2:0]       seg_an_r;
    logic             res_ready_s;
    logic             accept_s;
    logic [7:0]       conv_ones_s;
    logic [7:0]       conv_tens_s;
    logic [7:0]       conv_sign_s;
    logic             conv_sign_led_s;
    logic             conv_flag_led_s;
`ifndef ALU_DISP_HEX_EN
    logic [4:0]       mag_s;
    logic [4:0]       ones_val_s;
    logic             tens_one_s;
`endif

    // Ready whenever not converting; held low while reset is applied.
    always_comb begin
        res_ready_s = 1'b0;
        if (rst) begin
            res_ready_s = 1'b0;
        end else begin
            res_ready_s = (state_r != LOAD);
        end
    end

    assign accept_s      = res.res_valid & res_ready_s;
    assign res.res_ready = res_ready_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: accept from IDLE/SHOW, LOAD always finishes in one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: state_s = SHOW;
            SHOW: begin
                if (accept_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = SHOW;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Capture the producer's result on the handshake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_data_r <= 5'd0;
            cap_flag_r <= 1'b0;
        end else if (accept_s) begin
            cap_data_r <= res.res_data;
            cap_flag_r <= res.res_is_flag;
        end else begin
            cap_data_r <= cap_data_r;
            cap_flag_r <= cap_flag_r;
        end
    end

`ifndef ALU_DISP_HEX_EN
    // Signed decimal split: magnitude 0..16 into tens (0/1) and ones.
    always_comb begin
        mag_s      = 5'd0;
        tens_one_s = 1'b0;
        ones_val_s = 5'd0;
        if (cap_data_r[4]) begin
            mag_s = (~cap_data_r) + 5'd1;
        end else begin
            mag_s = cap_data_r;
        end
        if (mag_s >= 5'd10) begin
            tens_one_s = 1'b1;
            ones_val_s = mag_s - 5'd10;
        end else begin
            tens_one_s = 1'b0;
            ones_val_s = mag_s;
        end
    end
`endif

    // Segment patterns and LED values for the captured result.
    always_comb begin
        conv_ones_s     = SEG_BLANK;
        conv_tens_s     = SEG_BLANK;
        conv_sign_s     = SEG_BLANK;
        conv_sign_led_s = 1'b0;
        conv_flag_led_s = 1'b0;
        if (cap_flag_r) begin
            conv_ones_s     = seg_encode({3'b000, cap_data_r[0]});
            conv_flag_led_s = cap_data_r[0];
        end else begin
`ifdef ALU_DISP_HEX_EN
            conv_ones_s     = seg_encode(cap_data_r[3:0]);
            conv_tens_s     = seg_encode({3'b000, cap_data_r[4]});
            conv_sign_led_s = cap_data_r[4];
`else
            conv_ones_s     = seg_encode(ones_val_s[3:0]);
            if (tens_one_s) begin
                conv_tens_s = seg_encode(4'h1);
            end else begin
                conv_tens_s = SEG_BLANK;
            end
            if (cap_data_r[4]) begin
                conv_sign_s = SEG_MINUS;
            end else begin
                conv_sign_s = SEG_BLANK;
            end
            conv_sign_led_s = cap_data_r[4];
`endif
        end
    end

    // Digit registers and LEDs update on the LOAD->SHOW edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_ones_r <= SEG_BLANK;
            dig_tens_r <= SEG_BLANK;
            dig_sign_r <= SEG_BLANK;
            sign_led_r <= 1'b0;
            flag_led_r <= 1'b0;
        end else if (state_r == LOAD) begin
            dig_ones_r <= conv_ones_s;
            dig_tens_r <= conv_tens_s;
            dig_sign_r <= conv_sign_s;
            sign_led_r <= conv_sign_led_s;
            flag_led_r <= conv_flag_led_s;
        end else begin
            dig_ones_r <= dig_ones_r;
            dig_tens_r <= dig_tens_r;
            dig_sign_r <= dig_sign_r;
            sign_led_r <= sign_led_r;
            flag_led_r <= flag_led_r;
        end
    end

    // Scan divider: each digit stays enabled for SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {CNT_W{1'b0}};
            idx_r     <= 2'd0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {CNT_W{1'b0}};
            if (idx_r == 2'd2) begin
                idx_r <= 2'd0;
            end else begin
                idx_r <= idx_r + 2'd1;
            end
        end else begin
            div_cnt_r <= div_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            idx_r     <= idx_r;
        end
    end

    // Segment and anode outputs registered together so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out_r <= SEG_BLANK;
            seg_an_r  <= 3'b111;
        end else begin
            seg_an_r <= an_decode(idx_r);
            case (idx_r)
                2'd0:    seg_out_r <= dig_ones_r;
                2'd1:    seg_out_r <= dig_tens_r;
                2'd2:    seg_out_r <= dig_sign_r;
                default: seg_out_r <= SEG_BLANK;
            endcase
        end
    end

    assign seg_out  = seg_out_r;
    assign seg_an   = seg_an_r;
    assign sign_led = sign_led_r;
    assign flag_led = flag_led_r;

endmodule : alu_result_display

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display with a short scan period.
// Build with ALU_DISP_HEX_EN defined to check the raw-hex display mode.
module tb_alu_result_display;

    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 16;

    typedef struct {
        logic [4:0] data;
        logic       is_flag;
        logic [7:0] ones;
        logic [7:0] tens;
        logic [7:0] sign;
        logic       sl;
        logic       fl;
    } vec_t;

    typedef struct {
        logic [7:0] ones;
        logic [7:0] tens;
        logic [7:0] sign;
        logic       sl;
        logic       fl;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] seg_out;
    logic [2:0] seg_an;
    logic       sign_led;
    logic       flag_led;

    int n_checks;
    int n_fail;

    exp_t sb_q[$];
    vec_t vecs[$];

    alu_res_if bus ();

    alu_result_display #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .res      (bus),
        .seg_out  (seg_out),
        .seg_an   (seg_an),
        .sign_led (sign_led),
        .flag_led (flag_led)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] d, input logic f, input logic [7:0] o,
                                input logic [7:0] t, input logic [7:0] s,
                                input logic sl, input logic fl);
        vec_t v;
        v.data = d; v.is_flag = f; v.ones = o; v.tens = t; v.sign = s; v.sl = sl; v.fl = fl;
        return v;
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.ones = v.ones; e.tens = v.tens; e.sign = v.sign; e.sl = v.sl; e.fl = v.fl;
        return e;
    endfunction

    // One handshake; returns 1 ns after the accepting edge.
    task automatic send(input logic [4:0] d, input logic f);
        int w;
        w = 0;
        @(negedge clk);
        bus.res_valid   = 1'b1;
        bus.res_data    = d;
        bus.res_is_flag = f;
        while (!bus.res_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("send_timeout", 32'(w < 20), 32'd1);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        chk("ready_low_in_load", 32'(bus.res_ready), 32'd0);
    endtask

    // Observe a full scan and compare each digit against the oldest expectation.
    task automatic check_display(input string tag);
        exp_t       e;
        logic [7:0] g_ones;
        logic [7:0] g_tens;
        logic [7:0] g_sign;
        int         an_bad;
        g_ones = 8'h00;
        g_tens = 8'h00;
        g_sign = 8'h00;
        an_bad = 0;
        e = sb_q.pop_front();
        repeat (2) @(posedge clk);
        for (int c = 0; c < 3 * SCAN_DIV + 2; c++) begin
            @(negedge clk);
            case (seg_an)
                3'b110:  g_ones = seg_out;
                3'b101:  g_tens = seg_out;
                3'b011:  g_sign = seg_out;
                default: an_bad++;
            endcase
        end
        chk({tag, ".ones"}, 32'(g_ones), 32'(e.ones));
        chk({tag, ".tens"}, 32'(g_tens), 32'(e.tens));
        chk({tag, ".sign"}, 32'(g_sign), 32'(e.sign));
        chk({tag, ".sign_led"}, 32'(sign_led), 32'(e.sl));
        chk({tag, ".flag_led"}, 32'(flag_led), 32'(e.fl));
        chk({tag, ".an_onehot"}, 32'(an_bad), 32'd0);
    endtask

    initial begin
        exp_t       eb;
        logic [2:0] an_exp;
        n_checks = 0;
        n_fail   = 0;

`ifdef ALU_DISP_HEX_EN
        vecs.push_back(mk(5'b11101, 1'b0, 8'hA1, 8'hF9, 8'hFF, 1'b1, 1'b0));
        vecs.push_back(mk(5'b10000, 1'b0, 8'hC0, 8'hF9, 8'hFF, 1'b1, 1'b0));
        vecs.push_back(mk(5'b01111, 1'b0, 8'h8E, 8'hC0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(5'b00001, 1'b1, 8'hF9, 8'hFF, 8'hFF, 1'b0, 1'b1));
        vecs.push_back(mk(5'b00000, 1'b0, 8'hC0, 8'hC0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(5'b11110, 1'b1, 8'hC0, 8'hFF, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(5'b10110, 1'b0, 8'h82, 8'hF9, 8'hFF, 1'b1, 1'b0));
        vecs.push_back(mk(5'b01001, 1'b0, 8'h90, 8'hC0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(5'b11111, 1'b0, 8'h8E, 8'hF9, 8'hFF, 1'b1, 1'b0));
`else
        vecs.push_back(mk(5'b11101, 1'b0, 8'hB0, 8'hFF, 8'hBF, 1'b1, 1'b0));
        vecs.push_back(mk(5'b10000, 1'b0, 8'h82, 8'hF9, 8'hBF, 1'b1, 1'b0));
        vecs.push_back(mk(5'b01111, 1'b0, 8'h92, 8'hF9, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(5'b00001, 1'b1, 8'hF9, 8'hFF, 8'hFF, 1'b0, 1'b1));
        vecs.push_back(mk(5'b00000, 1'b0, 8'hC0, 8'hFF, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(5'b11110, 1'b1, 8'hC0, 8'hFF, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(5'b10110, 1'b0, 8'hC0, 8'hF9, 8'hBF, 1'b1, 1'b0));
        vecs.push_back(mk(5'b01001, 1'b0, 8'h90, 8'hFF, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(5'b11111, 1'b0, 8'hF9, 8'hFF, 8'hBF, 1'b1, 1'b0));
`endif

        rst             = 1'b1;
        bus.res_valid   = 1'b0;
        bus.res_data    = 5'd0;
        bus.res_is_flag = 1'b0;

        // Reset: outputs blank and not ready while rst is held.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst.seg_out", 32'(seg_out), 32'h0000_00FF);
            chk("rst.seg_an", 32'(seg_an), 32'd7);
            chk("rst.ready", 32'(bus.res_ready), 32'd0);
            chk("rst.leds", 32'({sign_led, flag_led}), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.ready", 32'(bus.res_ready), 32'd1);

        // Idle scan walk: each enable held for SCAN_DIV cycles, all blank.
        for (int k = 1; k <= 3 * SCAN_DIV; k++) begin
            @(posedge clk);
            #1;
            if (k <= SCAN_DIV) begin
                an_exp = 3'b110;
            end else if (k <= 2 * SCAN_DIV) begin
                an_exp = 3'b101;
            end else begin
                an_exp = 3'b011;
            end
            chk("idle.seg_an", 32'(seg_an), 32'(an_exp));
            chk("idle.seg_out", 32'(seg_out), 32'h0000_00FF);
        end

        // Table-driven numeric and flag results.
        for (int i = 0; i < vecs.size(); i++) begin
            sb_q.push_back(to_exp(vecs[i]));
            send(vecs[i].data, vecs[i].is_flag);
            @(posedge clk);
            #1;
            chk("ready_back_in_show", 32'(bus.res_ready), 32'd1);
            check_display($sformatf("vec%0d", i));
        end

        // Back-to-back: 7 accepted, 9 stalled through LOAD then accepted.
        @(negedge clk);
        bus.res_valid   = 1'b1;
        bus.res_is_flag = 1'b0;
        bus.res_data    = 5'd7;
        @(posedge clk);
        #1;
        chk("b2b.first_accept", 32'(bus.res_ready), 32'd0);
        bus.res_data = 5'd9;
        @(posedge clk);
        #1;
        chk("b2b.stall_release", 32'(bus.res_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b.second_accept", 32'(bus.res_ready), 32'd0);
        bus.res_valid = 1'b0;
        sb_q.push_back(to_exp(vecs[7]));
        check_display("b2b");

        // Reset on the LOAD edge discards -2 and blanks everything.
        send(5'b11110, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_load.ready", 32'(bus.res_ready), 32'd0);
        chk("rst_load.seg_an", 32'(seg_an), 32'd7);
        chk("rst_load.seg_out", 32'(seg_out), 32'h0000_00FF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_load.ready_after", 32'(bus.res_ready), 32'd1);
        eb.ones = 8'hFF; eb.tens = 8'hFF; eb.sign = 8'hFF; eb.sl = 1'b0; eb.fl = 1'b0;
        sb_q.push_back(eb);
        check_display("rst_load");

        // -2 sent again after the aborted conversion.
`ifdef ALU_DISP_HEX_EN
        eb.ones = 8'h86; eb.tens = 8'hF9; eb.sign = 8'hFF; eb.sl = 1'b1; eb.fl = 1'b0;
`else
        eb.ones = 8'hA4; eb.tens = 8'hFF; eb.sign = 8'hBF; eb.sl = 1'b1; eb.fl = 1'b0;
`endif
        sb_q.push_back(eb);
        send(5'b11110, 1'b0);
        check_display("minus2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_result_display
